// File: rtl/slide_gen.sv
// Sliding-piece move generator: loads a 64-byte board over Avalon-MM and writes
// one successor board per legal rook/bishop/queen move to an output region.
module slide_gen #(
  parameter int MODE      = 0,
  parameter int MAX_RANGE = 7,
  parameter int MAX_MOVES = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {IDLE, LOAD, FIND, SCAN, EMIT, DONE} state_t;

  localparam logic [3:0] DIR_FIRST = (MODE == 1) ? 4'd4 : 4'd0;
  localparam logic [3:0] DIR_LAST  = (MODE == 0) ? 4'd3 : 4'd7;
  localparam logic [2:0] RANGE     = 3'(MAX_RANGE);
  localparam logic [4:0] MOVES_CAP = 5'(MAX_MOVES);

  state_t      state, state_nx;
  logic [31:0] in_base, out_base;
  logic [7:0]  piece;
  logic [4:0]  count;
  logic [7:0]  board [64];
  logic [5:0]  idx;
  logic        pending;
  logic [5:0]  src, tgt;
  logic [3:0]  dir;
  logic [2:0]  step;
  logic [2:0]  row, col;

  logic        busy, start;
  logic signed [4:0] dr, dc, nr, nc;
  logic        off_board, ray_blocked, emit, capture;
  logic [5:0]  tsq;
  logic [7:0]  tval;
  logic        unused_rdata;

  assign unused_rdata = ^master_readdata[31:8];

  assign busy  = (state != IDLE) && (state != DONE);
  assign start = slave_write && (slave_address == 4'd0) && !busy;

  // Slave side: only a count read during a run is held off.
  always_comb begin
    slave_waitrequest = slave_read && (slave_address == 4'd0) && busy;
    slave_readdata    = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = {27'd0, count};
        4'd1:    slave_readdata = in_base;
        4'd2:    slave_readdata = {24'd0, piece};
        4'd3:    slave_readdata = out_base;
        default: slave_readdata = '0;
      endcase
    end
  end

  // Ray step vector for the current direction (row delta, column delta).
  always_comb begin
    dr = '0;
    dc = '0;
    case (dir)
      4'd0: begin dr = 5'sd1;  dc = 5'sd0;  end
      4'd1: begin dr = -5'sd1; dc = 5'sd0;  end
      4'd2: begin dr = 5'sd0;  dc = 5'sd1;  end
      4'd3: begin dr = 5'sd0;  dc = -5'sd1; end
      4'd4: begin dr = 5'sd1;  dc = 5'sd1;  end
      4'd5: begin dr = 5'sd1;  dc = -5'sd1; end
      4'd6: begin dr = -5'sd1; dc = 5'sd1;  end
      4'd7: begin dr = -5'sd1; dc = -5'sd1; end
      default: begin dr = '0; dc = '0; end
    endcase
  end

  assign nr          = $signed({2'b00, row}) + dr;
  assign nc          = $signed({2'b00, col}) + dc;
  assign off_board   = (nr[4:3] != 2'b00) || (nc[4:3] != 2'b00);
  assign tsq         = {nr[2:0], nc[2:0]};
  assign tval        = board[tsq];
  assign ray_blocked = (step == RANGE) || off_board ||
                       ((tval != 8'd0) && (tval[7] == piece[7]));
  assign emit        = !ray_blocked;
  assign capture     = tval != 8'd0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = LOAD;
      LOAD: if (pending && master_readdatavalid && idx == 6'd63) state_nx = FIND;
      FIND: begin
        if (piece == 8'd0)             state_nx = DONE;
        else if (board[idx] == piece)  state_nx = SCAN;
        else if (idx == 6'd63)         state_nx = DONE;
      end
      SCAN: begin
        if (dir > DIR_LAST) state_nx = DONE;
        else if (emit)      state_nx = EMIT;
      end
      EMIT: begin
        if (!master_waitrequest && idx == 6'd63)
          state_nx = (count + 5'd1 == MOVES_CAP) ? DONE : SCAN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_base  <= '0;
      out_base <= '0;
      piece    <= '0;
      count    <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      src      <= '0;
      tgt      <= '0;
      dir      <= '0;
      step     <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      if (slave_write && !busy) begin
        case (slave_address)
          4'd0: begin count <= '0; idx <= '0; pending <= 1'b0; end
          4'd1: in_base  <= slave_writedata;
          4'd2: piece    <= slave_writedata[7:0];
          4'd3: out_base <= slave_writedata;
          default: ;
        endcase
      end
      case (state)
        LOAD: begin
          if (master_read && !master_waitrequest) pending <= 1'b1;
          if (pending && master_readdatavalid) begin
            pending <= 1'b0;
            idx     <= idx + 6'd1;
          end
        end
        FIND: begin
          if (piece != 8'd0 && board[idx] == piece) begin
            src  <= idx;
            row  <= idx[5:3];
            col  <= idx[2:0];
            dir  <= DIR_FIRST;
            step <= '0;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        SCAN: begin
          if (dir <= DIR_LAST) begin
            if (emit) begin
              tgt <= tsq;
              idx <= '0;
            end
            // A capture ends the ray now; the direction index may pass DIR_LAST,
            // which SCAN later treats as "all rays exhausted".
            if (emit && !capture) begin
              row  <= nr[2:0];
              col  <= nc[2:0];
              step <= step + 3'd1;
            end else begin
              dir  <= dir + 4'd1;
              step <= '0;
              row  <= src[5:3];
              col  <= src[2:0];
            end
          end
        end
        EMIT: begin
          if (!master_waitrequest) begin
            idx <= idx + 6'd1;
            if (idx == 6'd63) count <= count + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && pending && master_readdatavalid)
      board[idx] <= master_readdata[7:0];
  end

  always_comb begin
    master_read      = (state == LOAD) && !pending;
    master_write     = (state == EMIT);
    master_address   = '0;
    master_writedata = '0;
    if (state == LOAD) master_address = in_base + {26'd0, idx};
    if (state == EMIT) begin
      master_address = out_base + {21'd0, count, idx};
      if (idx == src)      master_writedata = '0;
      else if (idx == tgt) master_writedata = {24'd0, piece};
      else                 master_writedata = {24'd0, board[idx]};
    end
  end

endmodule

// File: tb/tb_slide_gen.sv
// Bench for slide_gen: four parameter variants share one byte-addressed memory
// model; expected output boards are queued at start and checked as writes land.
module tb_slide_gen;
  localparam int          N        = 4;
  localparam int          BUDGET   = 20000;
  localparam logic [31:0] IN_BASE  = 32'h100;
  localparam logic [31:0] OUT_BASE = 32'h400;

  logic clk, rst_n;
  logic [N-1:0]       s_wait, s_read, s_write;
  logic [N-1:0][3:0]  s_addr;
  logic [N-1:0][31:0] s_rdata, s_wdata;
  logic [N-1:0]       m_wait, m_read, m_write, m_rvalid;
  logic [N-1:0][31:0] m_addr, m_rdata, m_wdata;

  for (genvar g = 0; g < N; g++) begin : g_dut
    slide_gen #(
      .MODE     (g == 1 ? 1 : (g == 2 ? 2 : 0)),
      .MAX_RANGE(g == 2 ? 1 : 7),
      .MAX_MOVES(g == 3 ? 5 : 27)
    ) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .slave_waitrequest   (s_wait[g]),
      .slave_address       (s_addr[g]),
      .slave_read          (s_read[g]),
      .slave_readdata      (s_rdata[g]),
      .slave_write         (s_write[g]),
      .slave_writedata     (s_wdata[g]),
      .master_waitrequest  (m_wait[g]),
      .master_address      (m_addr[g]),
      .master_read         (m_read[g]),
      .master_readdata     (m_rdata[g]),
      .master_readdatavalid(m_rvalid[g]),
      .master_write        (m_write[g]),
      .master_writedata    (m_wdata[g])
    );
  end

  function automatic int mode_of(input int g);
    return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
  endfunction
  function automatic int range_of(input int g);
    return (g == 2) ? 1 : 7;
  endfunction
  function automatic int maxm_of(input int g);
    return (g == 3) ? 5 : 27;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int inst;
    int piece;
    int sq0, v0, sq1, v1, sq2, v2;
    int waits;
    int exp_count;
    int poke_busy;
  } vec_t;

  int   total, bad;
  int   sel, waits, wcnt, wr_count;
  bit   sb_on, rv_next, waited;
  logic [7:0]  rv_data;
  logic [31:0] hold_addr;
  logic [7:0]  mem [4096];
  int   bd [64];
  wr_t  exp_q [$];
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: decisions on the falling edge, seen by the DUT on the next rise.
  always @(negedge clk) begin
    wr_t e;
    m_rvalid = '0;
    m_rdata  = '0;
    m_wait   = '0;
    if (!rst_n) begin
      wcnt = 0; rv_next = 0; waited = 0;
    end else begin
      if (rv_next) begin
        m_rvalid[sel] = 1'b1;
        m_rdata[sel]  = {24'd0, rv_data};
        rv_next = 0;
      end
      if (m_read[sel] || m_write[sel]) begin
        if (wcnt < waits) begin
          if (wcnt == 0) hold_addr = m_addr[sel];
          m_wait[sel] = 1'b1;
          wcnt++;
          waited = 1;
        end else begin
          if (waited) chk("hold_addr", m_addr[sel], hold_addr);
          wcnt = 0;
          waited = 0;
          if (m_write[sel]) begin
            mem[m_addr[sel][11:0]] = m_wdata[sel][7:0];
            wr_count++;
            if (sb_on) begin
              if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_write: got addr %0h want no write", m_addr[sel]);
              end else begin
                e = exp_q.pop_front();
                chk("wr_addr", m_addr[sel], e.addr);
                chk("wr_data", m_wdata[sel], {24'd0, e.data});
              end
            end
          end else begin
            rv_next = 1;
            rv_data = mem[m_addr[sel][11:0]];
          end
        end
      end
    end
  end

  task automatic slave_wr(input int a, input logic [31:0] d);
    @(negedge clk);
    s_write[sel] = 1'b1; s_addr[sel] = 4'(a); s_wdata[sel] = d;
    @(posedge clk); #1;
    s_write[sel] = 1'b0;
  endtask

  task automatic slave_rd(input int a, output logic [31:0] d, output int stall);
    @(negedge clk);
    s_read[sel] = 1'b1; s_addr[sel] = 4'(a);
    #1;
    stall = 0;
    while (s_wait[sel] && stall < BUDGET) begin
      @(negedge clk); #1;
      stall++;
    end
    chk("rd_timeout", 32'(s_wait[sel]), 32'd0);
    d = s_rdata[sel];
    @(posedge clk); #1;
    s_read[sel] = 1'b0;
  endtask

  task automatic build_expected(input int g, input int p);
    int dr [8] = '{1, -1, 0, 0, 1, 1, -1, -1};
    int dc [8] = '{0, 0, 1, -1, 1, -1, 1, -1};
    int tg [$];
    int src = -1;
    int d0 = (mode_of(g) == 1) ? 4 : 0;
    int d1 = (mode_of(g) == 0) ? 3 : 7;
    int n;
    wr_t e;
    if (p != 0)
      for (int i = 0; i < 64; i++) if (src < 0 && bd[i] == p) src = i;
    if (src >= 0) begin
      for (int d = d0; d <= d1; d++) begin
        for (int s = 1; s <= range_of(g); s++) begin
          int r = src / 8 + dr[d] * s;
          int c = src % 8 + dc[d] * s;
          if (r < 0 || r > 7 || c < 0 || c > 7) break;
          if (bd[r*8+c] == 0) tg.push_back(r*8+c);
          else begin
            if ((bd[r*8+c] < 0) != (p < 0)) tg.push_back(r*8+c);
            break;
          end
        end
      end
    end
    n = (tg.size() > maxm_of(g)) ? maxm_of(g) : tg.size();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 64; i++) begin
        e.addr = OUT_BASE + 32'(k * 64 + i);
        if (i == src)        e.data = 8'd0;
        else if (i == tg[k]) e.data = 8'(p);
        else                 e.data = 8'(bd[i]);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic load_board(input vec_t v);
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    for (int i = 0; i < 64; i++) bd[i] = 0;
    if (v.sq0 >= 0) bd[v.sq0] = v.v0;
    if (v.sq1 >= 0) bd[v.sq1] = v.v1;
    if (v.sq2 >= 0) bd[v.sq2] = v.v2;
    for (int i = 0; i < 64; i++) mem[IN_BASE[11:0] + 12'(i)] = 8'(bd[i]);
  endtask

  task automatic run_vec(input int t);
    vec_t v;
    logic [31:0] d;
    int stall;
    v = vecs[t];
    sel = v.inst; waits = v.waits;
    load_board(v);
    exp_q.delete();
    build_expected(v.inst, v.piece);
    wr_count = 0;
    sb_on = 1;
    slave_wr(1, IN_BASE);
    slave_wr(2, 32'(v.piece) & 32'hFF);
    slave_wr(3, OUT_BASE);
    slave_wr(0, 32'd0);
    if (v.poke_busy != 0) slave_wr(2, 32'h33);
    slave_rd(0, d, stall);
    chk($sformatf("count_v%0d", t), d, 32'(v.exp_count));
    chk($sformatf("writes_v%0d", t), 32'(wr_count), 32'(v.exp_count * 64));
    chk($sformatf("sb_left_v%0d", t), 32'(exp_q.size()), 32'd0);
    if (v.exp_count == 0) chk("absent_stall_short", 32'(stall > 0 && stall <= 400), 32'd1);
    if (v.poke_busy != 0) begin
      slave_rd(2, d, stall);
      chk("busy_write_ignored", d, 32'(v.piece) & 32'hFF);
    end
    sb_on = 0;
  endtask

  initial begin : main
    logic [31:0] d;
    int stall, wr_snap;
    vec_t v;
    total = 0; bad = 0; sel = 0; waits = 0; wr_count = 0; sb_on = 0;
    s_read = '0; s_write = '0; s_addr = '0; s_wdata = '0;
    rst_n = 1'b0;

    //          inst piece  sq0 v0   sq1 v1   sq2 v2  waits count poke
    vecs[0] = '{0,   9,     0,  9,   -1, 0,   -1, 0,  0,    14,   0};
    vecs[1] = '{1,   9,     27, 9,   36, -1,  18, 1,  0,    7,    0};
    vecs[2] = '{2,   48,    63, 48,  -1, 0,   -1, 0,  0,    3,    0};
    vecs[3] = '{0,   5,     0,  9,   -1, 0,   -1, 0,  0,    0,    0};
    vecs[4] = '{3,   9,     0,  9,   -1, 0,   -1, 0,  3,    5,    0};
    vecs[5] = '{0,   -3,    35, -3,  51, 1,   33, -2, 0,    11,   1};

    repeat (3) @(negedge clk);
    chk("reset_master", {28'd0, m_read | m_write}, 32'd0);
    chk("reset_addr", m_addr[0] | m_addr[1] | m_addr[2] | m_addr[3], 32'd0);
    rst_n = 1'b1;

    slave_rd(0, d, stall);
    chk("idle_count", d, 32'd0);
    chk("idle_no_stall", 32'(stall), 32'd0);
    slave_wr(1, 32'h1234);
    slave_rd(1, d, stall);
    chk("reg1_readback", d, 32'h1234);
    slave_rd(7, d, stall);
    chk("addr7_zero", d, 32'd0);

    for (int t = 0; t < 6; t++) run_vec(t);

    // Reset while board 0 is being emitted.
    v = vecs[0];
    sel = 0; waits = 0;
    load_board(v);
    wr_count = 0;
    slave_wr(1, IN_BASE);
    slave_wr(2, 32'd9);
    slave_wr(3, OUT_BASE);
    slave_wr(0, 32'd0);
    for (int c = 0; c < BUDGET && wr_count < 100; c++) @(negedge clk);
    chk("reached_emit", 32'(wr_count >= 100), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_m_read", {31'd0, m_read[0]}, 32'd0);
    chk("rst_m_write", {31'd0, m_write[0]}, 32'd0);
    chk("rst_m_addr", m_addr[0], 32'd0);
    chk("rst_m_wdata", m_wdata[0], 32'd0);
    chk("rst_s_wait", {31'd0, s_wait[0]}, 32'd0);
    wr_snap = wr_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_writes_after_rst", 32'(wr_count), 32'(wr_snap));
    slave_rd(0, d, stall);
    chk("rst_count", d, 32'd0);
    chk("rst_no_stall", 32'(stall), 32'd0);
    slave_rd(3, d, stall);
    chk("rst_out_base", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slide_gen.md
SLIDE_GEN -- requirements
Module: slide_gen

Parameters
REQ-001 The block SHALL have parameter MODE, default 0, meaning direction set: 0 = orthogonal (rook), 1 = diagonal (bishop), 2 = both (queen).
REQ-002 The block SHALL have parameter MAX_RANGE, default 7, meaning maximum steps per ray (1..7); MODE=2 with MAX_RANGE=1 gives king moves without castling.
REQ-003 The block SHALL have parameter MAX_MOVES, default 27, meaning the cap on emitted boards per run (1..27).

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports slave_waitrequest (out, 1), slave_address (in, 4), slave_read (in, 1), slave_readdata (out, 32), slave_write (in, 1), slave_writedata (in, 32): the Avalon-MM control slave.
REQ-007 The block SHALL have ports master_waitrequest (in, 1), master_address (out, 32), master_read (out, 1), master_readdata (in, 32), master_readdatavalid (in, 1), master_write (out, 1), master_writedata (out, 32): the byte-per-address SDRAM master, with data in bits [7:0].

Function
REQ-008 Slave register map SHALL be: addr0 write = start; addr0 read = move count; addr1 = input board base; addr2 = piece code, signed 8-bit in [7:0]; addr3 = output base. addr1..3 SHALL be read/write.
REQ-009 slave_waitrequest SHALL be asserted only while slave_read=1, slave_address=0, and busy; all other accesses SHALL complete with waitrequest low.
REQ-010 Writes to any address while busy SHALL be ignored.
REQ-011 Board encoding SHALL be: square = row*8+col (0..63); 0 = empty; >0 = white; <0 = black.
REQ-012 FSM states SHALL be IDLE, LOAD, FIND, SCAN, EMIT, DONE; start moves IDLE or DONE to LOAD on the next edge, and the count clears to 0.
REQ-013 LOAD SHALL read 64 bytes from in_base+i (i = 0..63) into a local board, one outstanding read at a time.
REQ-014 On the master side, the address and read/write strobe SHALL be held stable while master_waitrequest=1.
REQ-015 During LOAD, a byte SHALL be captured only on master_readdatavalid=1.
REQ-016 FIND SHALL locate the lowest square equal to the piece code; if the code is 0 or absent, go to DONE with count 0 and no master writes.
REQ-017 Direction order SHALL be: orthogonal N(+8), S(-8), E(+1), W(-1), then diagonal NE(+9), NW(+7), SE(-7), SW(-9); MODE=2 SHALL use orthogonal then diagonal.
REQ-018 Each ray SHALL step 1..MAX_RANGE and stop on row/column overflow; column wrap SHALL never produce a move.
REQ-019 For each target square: empty -> emit, continue; opposite sign -> emit capture, end ray; same sign -> end ray without emit.
REQ-020 EMIT for move k SHALL write 64 bytes to out_base + k*64 + i, equal to the local board with source = 0 and target = piece code; the local board itself SHALL stay unmodified.
REQ-021 The count SHALL increment after each completed EMIT; on reaching MAX_MOVES, the FSM SHALL go to DONE.
REQ-022 DONE SHALL drive count onto slave_readdata for addr0 reads, zero-extended, and release waitrequest on the same cycle.
REQ-023 Reads of addr4..15 SHALL return 0.

Reset
REQ-024 On rst_n low, the FSM SHALL go to IDLE immediately, including mid-LOAD or mid-EMIT.
REQ-025 On reset: master_read=0, master_write=0, master_address=0, master_writedata=0, slave_readdata=0, slave_waitrequest=0, count=0, and all config registers=0.
REQ-026 After a reset mid-run, no further master writes SHALL be issued.

Verification
REQ-027 MODE=0, empty board except 9 at square 0, start -> count 14; board 0 has sq0=0, sq8=9; exactly 896 master writes.
REQ-028 MODE=1, 9 at 27, -1 at 36, 1 at 18 -> count 7; targets in order 36, 34, 41, 48, 20, 13, 6; no board with target 55.
REQ-029 MODE=2, MAX_RANGE=1, 48 at 63 -> count 3; targets 55, 62, 54.
REQ-030 Piece code 5 absent from board -> count 0; zero master writes; addr0 read stalls only through LOAD+FIND.
REQ-031 master_waitrequest high 3 cycles per transfer, plus MAX_MOVES=5 on the REQ-027 board -> count 5, exactly 320 writes, identical data.
REQ-032 rst_n pulsed mid-EMIT -> all outputs at reset values within the same cycle; a following addr0 read returns 0 with no stall.
